// File: rtl/vga_timing_pipe.sv
// VGA timing generator: pixel-tick divider, h/v counters, sync/blank decode,
// and an alignment pipeline matching a pixel generator with PIPE ticks of latency.
module vga_timing_pipe #(
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int RGB_W    = 3,
    parameter int PIPE     = 0,
    parameter int SYNC_POL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic             video_on,
    output logic             p_tick,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a 1024-wide visible area still compares correctly
    localparam logic [10:0] H_VIS    = 11'(H_DISP);
    localparam logic [10:0] HS_BEG   = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_DISP);
    localparam logic [10:0] VS_BEG   = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_DISP + V_FP + V_SYNC);
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic        POL      = 1'(SYNC_POL);

    typedef struct packed {
        logic von;
        logic hs;
        logic vs;
    } stage_t;

    logic [3:0] div;
    logic [9:0] h, v;
    logic [10:0] h_x, v_x;

    stage_t             stg0;
    stage_t [PIPE:0]    stg_q;   // stages 1..PIPE+1
    stage_t [PIPE+1:0]  stg;     // stg[k] is stage k

    assign p_tick = (div == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (p_tick) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    assign h_x      = {1'b0, h};
    assign v_x      = {1'b0, v};
    assign stg0.von = (h_x < H_VIS) && (v_x < V_VIS);
    assign stg0.hs  = (h_x >= HS_BEG) && (h_x < HS_END);
    assign stg0.vs  = (v_x >= VS_BEG) && (v_x < VS_END);
    assign stg      = {stg_q, stg0};

    // Cleared stages read as blank/no-sync, so no stale pulse leaks out after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_q <= '0;
            rgb   <= '0;
        end else if (p_tick) begin
            stg_q <= stg[PIPE:0];
            rgb   <= stg[PIPE].von ? rgb_in : '0;
        end
    end

    assign pixel_x     = h;
    assign pixel_y     = v;
    assign video_on    = stg0.von;
    assign frame_start = p_tick && (h == 10'd0) && (v == 10'd0);
    assign hsync       = stg[PIPE+1].hs ~^ POL;
    assign vsync       = stg[PIPE+1].vs ~^ POL;
endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: default timing, a tiny PIPE=2 frame, and CLK_DIV=1 active-high sync.
module tb_vga_timing_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic [9:0] d_x, d_y;
    logic d_von, d_pt, d_fs, d_hs, d_vs;
    logic [2:0] d_rgb;
    logic [2:0] d_rgb_in = 3'd5;

    // small frame: H_TOTAL=16 (sync 10..12), V_TOTAL=8 (sync 5..6), PIPE=2
    logic [9:0] s_x, s_y;
    logic s_von, s_pt, s_fs, s_hs, s_vs;
    logic [2:0] s_rgb, s_rgb_in, s_d1;

    // CLK_DIV=1, active-high sync
    logic [9:0] f_x, f_y;
    logic f_von, f_pt, f_fs, f_hs, f_vs;
    logic [2:0] f_rgb;
    logic [2:0] f_rgb_in = 3'd3;

    vga_timing_pipe u_def (
        .clk(clk), .reset(reset), .rgb_in(d_rgb_in), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_von), .p_tick(d_pt), .frame_start(d_fs), .hsync(d_hs), .vsync(d_vs), .rgb(d_rgb));

    vga_timing_pipe #(
        .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE(2)
    ) u_sm (
        .clk(clk), .reset(reset), .rgb_in(s_rgb_in), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_von), .p_tick(s_pt), .frame_start(s_fs), .hsync(s_hs), .vsync(s_vs), .rgb(s_rgb));

    vga_timing_pipe #(.CLK_DIV(1), .SYNC_POL(1)) u_fast (
        .clk(clk), .reset(reset), .rgb_in(f_rgb_in), .pixel_x(f_x), .pixel_y(f_y),
        .video_on(f_von), .p_tick(f_pt), .frame_start(f_fs), .hsync(f_hs), .vsync(f_vs), .rgb(f_rgb));

    // pixel generator model with 2 ticks of latency: returns x[2:0]
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s_d1     <= '0;
            s_rgb_in <= '0;
        end else if (s_pt) begin
            s_d1     <= s_x[2:0];
            s_rgb_in <= s_d1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int n;
        int x;
        int y;
        int pt;
        int von;
        int fs;
        int hs;
        int rgb;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int ti, f_hs_cnt, f_hs_first, f_pt_bad;
        int fs_cnt, fs_first, fs_last, fs_bad, vs_lo, von_cnt, pt_cnt, al_bad;
        int idx, p, xp, yp, e_hs, e_vs, e_rgb, found;

        //        n     x    y  pt von fs hs rgb
        tbl = '{'{   0,   0, 0, 0, 1, 0, 1, 0},
                '{   1,   0, 0, 1, 1, 1, 1, 0},
                '{   2,   1, 0, 0, 1, 0, 1, 5},
                '{1279, 639, 0, 1, 1, 0, 1, 5},
                '{1280, 640, 0, 0, 0, 0, 1, 5},
                '{1282, 641, 0, 0, 0, 0, 1, 0},
                '{1313, 656, 0, 1, 0, 0, 1, 0},
                '{1314, 657, 0, 0, 0, 0, 0, 0},
                '{1505, 752, 0, 1, 0, 0, 0, 0},
                '{1506, 753, 0, 0, 0, 0, 1, 0},
                '{1599, 799, 0, 1, 0, 0, 1, 0},
                '{1600,   0, 1, 0, 1, 0, 1, 0},
                '{1601,   0, 1, 1, 1, 0, 1, 0},
                '{1602,   1, 1, 0, 1, 0, 1, 5}};

        // reset state
        reset = 1'b1;
        repeat (3) step();
        chk("rst_def_x", int'(d_x), 0);
        chk("rst_def_y", int'(d_y), 0);
        chk("rst_def_pt", int'(d_pt), 0);
        chk("rst_def_von", int'(d_von), 1);
        chk("rst_def_hs", int'(d_hs), 1);
        chk("rst_def_vs", int'(d_vs), 1);
        chk("rst_def_rgb", int'(d_rgb), 0);
        chk("rst_fast_pt", int'(f_pt), 1);
        chk("rst_fast_hs", int'(f_hs), 0);
        chk("rst_fast_vs", int'(f_vs), 0);

        // one and a bit lines on the default and fast instances
        reset = 1'b0;
        ti = 0; f_hs_cnt = 0; f_hs_first = -1; f_pt_bad = 0;
        for (int n = 0; n <= 1700; n++) begin
            if (n > 0) step();
            if (ti < 14 && tbl[ti].n == n) begin
                chk($sformatf("def_n%0d_x", n), int'(d_x), tbl[ti].x);
                chk($sformatf("def_n%0d_y", n), int'(d_y), tbl[ti].y);
                chk($sformatf("def_n%0d_pt", n), int'(d_pt), tbl[ti].pt);
                chk($sformatf("def_n%0d_von", n), int'(d_von), tbl[ti].von);
                chk($sformatf("def_n%0d_fs", n), int'(d_fs), tbl[ti].fs);
                chk($sformatf("def_n%0d_hs", n), int'(d_hs), tbl[ti].hs);
                chk($sformatf("def_n%0d_rgb", n), int'(d_rgb), tbl[ti].rgb);
                ti++;
            end
            if (f_pt !== 1'b1) f_pt_bad++;
            if (n < 800 && f_hs === 1'b1) begin
                f_hs_cnt++;
                if (f_hs_first < 0) f_hs_first = n;
            end
            if (n == 799) chk("fast_x_799", int'(f_x), 799);
            if (n == 800) begin
                chk("fast_wrap_x", int'(f_x), 0);
                chk("fast_wrap_y", int'(f_y), 1);
            end
            if (n == 1600) chk("fast_line2_y", int'(f_y), 2);
        end
        chk("table_rows_seen", ti, 14);
        chk("fast_pt_not_high", f_pt_bad, 0);
        chk("fast_hs_width", f_hs_cnt, 96);
        chk("fast_hs_first", f_hs_first, 657);

        // small instance: four frames
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        fs_cnt = 0; fs_first = -1; fs_last = -1; fs_bad = 0;
        vs_lo = 0; von_cnt = 0; pt_cnt = 0; al_bad = 0;
        for (int n = 0; n <= 1024; n++) begin
            if (n > 0) step();
            if (s_fs === 1'b1) begin
                if (fs_first < 0) fs_first = n;
                else if (n - fs_last != 256) fs_bad++;
                fs_last = n;
                fs_cnt++;
            end
            if (n >= 256 && n < 512) begin
                if (s_vs === 1'b0) vs_lo++;
                if (s_von === 1'b1) von_cnt++;
                if (s_pt === 1'b1) pt_cnt++;
            end
            if (n >= 256) begin
                // pins describe the coordinate three ticks behind the counters
                idx = int'(s_y) * 16 + int'(s_x);
                p = (idx + 128 - 3) % 128;
                xp = p % 16;
                yp = p / 16;
                e_hs = (xp >= 10 && xp <= 12) ? 0 : 1;
                e_vs = (yp >= 5 && yp <= 6) ? 0 : 1;
                e_rgb = (xp < 8 && yp < 4) ? (xp % 8) : 0;
                if (int'(s_hs) != e_hs || int'(s_vs) != e_vs || int'(s_rgb) != e_rgb) begin
                    if (al_bad < 4)
                        $display("FAIL sm_align n=%0d hs=%0d/%0d vs=%0d/%0d rgb=%0d/%0d",
                                 n, s_hs, e_hs, s_vs, e_vs, s_rgb, e_rgb);
                    al_bad++;
                end
            end
        end
        chk("sm_fs_first", fs_first, 1);
        chk("sm_fs_count", fs_cnt, 4);
        chk("sm_fs_period", fs_bad, 0);
        chk("sm_vs_low_clk", vs_lo, 64);
        chk("sm_von_clk", von_cnt, 64);
        chk("sm_ptick_per_frame", pt_cnt, 128);
        chk("sm_align_errors", al_bad, 0);

        // mid-frame reset while both syncs are active on the small instance
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (s_x == 10'd13 && s_y == 10'd5) found = 1;
            else step();
        end
        chk("mid_found", found, 1);
        chk("mid_pre_hs", int'(s_hs), 0);
        chk("mid_pre_vs", int'(s_vs), 0);
        reset = 1'b1;
        #1;
        chk("mid_x", int'(s_x), 0);
        chk("mid_y", int'(s_y), 0);
        chk("mid_von", int'(s_von), 1);
        chk("mid_pt", int'(s_pt), 0);
        chk("mid_hs", int'(s_hs), 1);
        chk("mid_vs", int'(s_vs), 1);
        chk("mid_rgb", int'(s_rgb), 0);
        chk("mid_def_rgb", int'(d_rgb), 0);
        repeat (3) step();
        chk("mid_hold_x", int'(s_x), 0);
        chk("mid_hold_hs", int'(s_hs), 1);
        reset = 1'b0;
        step();
        chk("restart_pt", int'(s_pt), 1);
        chk("restart_fs", int'(s_fs), 1);
        step();
        chk("restart_x", int'(s_x), 1);
        chk("restart_y", int'(s_y), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
